// File: rtl/dequantizer_1.sv
// JPEG inverse-quantization stage: multiplies each coefficient of an 8x8
// block (row-major) by the luminance quantization table entry at its index,
// with a one-entry output register and valid/ready on both sides.
module dequantizer_1 #(
    parameter bit SAT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] in_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] out_data_o,
    output logic [5:0]  out_index_o,
    output logic        sat_flag_o,
    output logic        done_o,
    output logic [7:0]  q_monitor_o
);

    localparam int unsigned DW = 16;
    localparam int unsigned IW = 6;
    localparam int unsigned QW = 8;
    localparam int unsigned PW = 25;

    localparam logic signed [PW-1:0] SAT_MAX = PW'(32767);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-32768);
    localparam logic [IW-1:0]        LAST_IDX = IW'(63);

    localparam logic [QW-1:0] Q_TABLE [64] = '{
        8'd16,  8'd11,  8'd10,  8'd16,  8'd24,  8'd40,  8'd51,  8'd61,
        8'd12,  8'd12,  8'd14,  8'd19,  8'd26,  8'd58,  8'd60,  8'd55,
        8'd14,  8'd13,  8'd16,  8'd24,  8'd40,  8'd57,  8'd69,  8'd56,
        8'd14,  8'd17,  8'd22,  8'd29,  8'd51,  8'd87,  8'd80,  8'd62,
        8'd18,  8'd22,  8'd37,  8'd56,  8'd68,  8'd109, 8'd103, 8'd77,
        8'd24,  8'd35,  8'd55,  8'd64,  8'd81,  8'd104, 8'd113, 8'd92,
        8'd49,  8'd64,  8'd78,  8'd87,  8'd103, 8'd121, 8'd120, 8'd101,
        8'd72,  8'd92,  8'd95,  8'd98,  8'd112, 8'd100, 8'd103, 8'd99
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic            ov_q, ov_d;
    logic [DW-1:0]   od_q, od_d;
    logic [IW-1:0]   oi_q, oi_d;
    logic            sat_q, sat_d;
    logic            done_q, done_d;

    logic [QW-1:0]        q_cur;
    logic signed [DW-1:0] din_s;
    logic signed [QW:0]   q_s;
    logic signed [PW-1:0] product;
    logic [DW-1:0]        res_data;
    logic                 res_sat;
    logic                 in_ready;
    logic                 accept;

    // Table lookup at the current input index; multiplier is exact in 25 bits.
    assign q_cur   = Q_TABLE[cnt_q];
    assign din_s   = in_data_i;
    assign q_s     = {1'b0, q_cur};
    assign product = PW'(din_s) * PW'(q_s);

    // Input can advance only in RUN when the output register is free or draining.
    assign in_ready = (state_q == RUN) && (!ov_q || out_ready_i);
    assign accept   = in_valid_i && in_ready;

    // Clamp to 16-bit signed when saturation is enabled, else keep low bits.
    always_comb begin
        res_data = product[DW-1:0];
        res_sat  = 1'b0;
        if (SAT_EN) begin
            if (product > SAT_MAX) begin
                res_data = 16'h7FFF;
                res_sat  = 1'b1;
            end else if (product < SAT_MIN) begin
                res_data = 16'h8000;
                res_sat  = 1'b1;
            end
        end
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        od_d    = od_q;
        oi_d    = oi_q;
        sat_d   = sat_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    od_d  = res_data;
                    sat_d = res_sat;
                    oi_d  = cnt_q;
                    ov_d  = 1'b1;
                    cnt_d = cnt_q + IW'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end else if (ov_q && out_ready_i) begin
                    ov_d = 1'b0;
                end
            end
            DRAIN: begin
                if (!ov_q || out_ready_i) begin
                    ov_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ov_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            oi_q    <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            oi_q    <= oi_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = ov_q;
    assign out_data_o  = od_q;
    assign out_index_o = oi_q;
    assign sat_flag_o  = sat_q;
    assign done_o      = done_q;
    assign q_monitor_o = q_cur;

endmodule

// File: tb/tb_dequantizer_1.sv
// Randomized and directed bench for dequantizer_1 against a transaction-level
// reference model (expected-output queue plus block phase tracking).
module tb_dequantizer_1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready,  in_ready_t;
    logic        out_valid, out_valid_t;
    logic [15:0] out_data,  out_data_t;
    logic [5:0]  out_index, out_index_t;
    logic        sat_flag,  sat_flag_t;
    logic        done,      done_t;
    logic [7:0]  q_mon,     q_mon_t;

    dequantizer_1 #(.SAT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_data_i(in_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .out_index_o(out_index),
        .sat_flag_o(sat_flag), .done_o(done), .q_monitor_o(q_mon)
    );

    dequantizer_1 #(.SAT_EN(1'b0)) dut_t (
        .clk(clk), .rst(rst), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(in_ready_t), .in_data_i(in_data), .out_valid_o(out_valid_t),
        .out_ready_i(out_ready), .out_data_o(out_data_t), .out_index_o(out_index_t),
        .sat_flag_o(sat_flag_t), .done_o(done_t), .q_monitor_o(q_mon_t)
    );

    always #5 clk = ~clk;

    int qtab [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    typedef struct {
        int data;
        int idx;
        bit sat;
        int trunc;
    } exp_t;

    exp_t exp_q [$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   mode = 0;          // 0 idle, 1 accepting inputs, 2 waiting for last output
    int   idx_m = 0;
    bit   done_exp = 1'b0;
    int   blocks_done = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    int   first_acc_cyc = 0;
    int   bp_cnt = 0;

    task automatic check(input string tag, input longint got, input longint want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    endtask

    function automatic exp_t model(input int d, input int idx);
        exp_t   e;
        longint p;
        p       = longint'(d) * longint'(qtab[idx]);
        e.idx   = idx;
        e.trunc = int'(p[15:0]);
        if (p > 32767) begin
            e.data = 32767;  e.sat = 1'b1;
        end else if (p < -32768) begin
            e.data = -32768; e.sat = 1'b1;
        end else begin
            e.data = int'(p); e.sat = 1'b0;
        end
        return e;
    endfunction

    // One clock: drive after the edge, check and advance the model at negedge.
    task automatic cycle(input bit st, input bit iv, input int d, input bit ordy);
        exp_t e;
        bit   rdy_exp;
        int   m0;
        @(posedge clk);
        #1;
        start = st; in_valid = iv; in_data = 16'(d); out_ready = ordy;
        @(negedge clk);
        cyc++;
        m0 = mode;
        rdy_exp = (mode == 1) && (exp_q.size() == 0 || ordy);
        check("in_ready", longint'(in_ready), longint'(rdy_exp));
        check("done", longint'(done), longint'(done_exp));
        if (done_exp) begin
            blocks_done++;
            last_done_cyc = cyc;
        end
        if (exp_q.size() > 0) begin
            check("out_valid", longint'(out_valid), 1);
            check("out_data", longint'($signed(out_data)), longint'(exp_q[0].data));
            check("out_index", longint'(out_index), longint'(exp_q[0].idx));
            check("sat_flag", longint'(sat_flag), longint'(exp_q[0].sat));
            check("trunc_data", longint'(out_data_t), longint'(exp_q[0].trunc));
            check("trunc_sat", longint'(sat_flag_t), 0);
        end else begin
            check("out_valid_idle", longint'(out_valid), 0);
            check("trunc_valid_idle", longint'(out_valid_t), 0);
        end
        if (m0 == 0) check("q_monitor_idle", longint'(q_mon), 16);
        done_exp = 1'b0;
        if (exp_q.size() > 0 && ordy) begin
            e = exp_q.pop_front();
            if (e.idx == 63) begin
                done_exp = 1'b1;
                mode = 0;
            end
        end
        if (iv && rdy_exp) begin
            check("q_monitor", longint'(q_mon), longint'(qtab[idx_m]));
            if (idx_m == 0) first_acc_cyc = cyc;
            exp_q.push_back(model(d, idx_m));
            if (idx_m == 63) begin
                idx_m = 0;
                mode = 2;
            end else begin
                idx_m++;
            end
        end
        if (m0 == 0 && st) begin
            mode = 1;
            idx_m = 0;
        end
    endtask

    function automatic int rand_data();
        int sel;
        sel = int'($urandom_range(0, 3));
        case (sel)
            0: return int'($urandom_range(0, 600)) - 300;
            1: return int'($signed(16'($urandom)));
            2: return 0;
            default: return ($urandom_range(0, 1) == 1) ? 32767 : -32768;
        endcase
    endfunction

    // Run one full block; kind selects data and handshake pattern.
    task automatic run_block(input int kind);
        int  target;
        bit  started;
        bit  st, iv, ordy;
        int  d;
        target  = blocks_done + 1;
        started = 1'b0;
        bp_cnt  = 0;
        for (int c = 0; c < 800 && blocks_done < target; c++) begin
            st = (mode == 0) && !started;
            iv = 1'b1;
            ordy = 1'b1;
            d = 1;
            case (kind)
                1: begin
                    d  = (idx_m == 1) ? -3 : (idx_m == 37) ? 5 : rand_data();
                    st = st || (idx_m == 30);
                end
                2: d = (idx_m == 0) ? 32767  : rand_data();
                3: d = (idx_m == 0) ? -32768 : rand_data();
                4: d = (idx_m == 0) ? 2047   : rand_data();
                5: begin
                    st   = st || ($urandom_range(0, 9) < 3);
                    iv   = ($urandom_range(0, 3) != 0);
                    ordy = ($urandom_range(0, 9) < 7);
                    d    = rand_data();
                end
                6: begin
                    if (exp_q.size() > 0 && exp_q[0].idx == 10 && bp_cnt < 5) begin
                        ordy = 1'b0;
                        bp_cnt++;
                    end
                end
                7: st = 1'b1;
                default: d = 1;
            endcase
            cycle(st, iv, d, ordy);
            if (mode != 0) started = 1'b1;
        end
        check("block_complete", longint'(blocks_done), longint'(target));
    endtask

    initial begin
        int d1;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_index", longint'(out_index), 0);
        check("rst_sat_flag", longint'(sat_flag), 0);
        check("rst_done", longint'(done), 0);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_q_monitor", longint'(q_mon), 16);
        #2 rst = 1'b0;

        run_block(0);   // unit inputs reproduce the table
        run_block(1);   // signed small values, stray start mid-block
        run_block(2);   // positive saturation / truncation at index 0
        run_block(3);   // negative saturation at index 0
        run_block(4);   // largest unsaturated value at index 0
        run_block(6);   // backpressure at index 10

        // Reset in the middle of a block at index 20.
        for (int c = 0; c < 200 && !(mode == 1 && idx_m == 20); c++)
            cycle(mode == 0, 1'b1, 1, 1'b1);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_out_data", longint'(out_data), 0);
        check("midrst_out_index", longint'(out_index), 0);
        check("midrst_sat_flag", longint'(sat_flag), 0);
        check("midrst_done", longint'(done), 0);
        check("midrst_in_ready", longint'(in_ready), 0);
        exp_q.delete();
        mode = 0; idx_m = 0; done_exp = 1'b0;
        #2 rst = 1'b0;
        run_block(0);

        // start held high through done: next block begins right after done.
        run_block(7);
        d1 = last_done_cyc;
        run_block(7);
        check("restart_gap", longint'(first_acc_cyc - d1), 1);
        run_block(0);

        for (int b = 0; b < 4; b++) run_block(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dequantizer_1.md
Name: dequantizer_1

Overview:
- Inverse-quantization stage of the JPEG decoder path: takes 64 quantized coefficients of one 8x8 block in row-major order and multiplies each by the standard JPEG luminance table entry for its index.
- Output is saturated to 16-bit signed and feeds the IDCT.
- Valid/ready streaming on both sides, 1-cycle latency, one coefficient per clock sustained, done pulse per block.

Parameters:
- SAT_EN, 1, 1 = clamp product to 16-bit signed; 0 = truncate to low 16 bits (sat_flag stays 0).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin a block; sampled only in IDLE
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle (combinational)
- in_data  in  16  signed quantized coefficient
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  16  signed dequantized coefficient
- out_index  out  6  table index (0..63) of out_data
- sat_flag  out  1  out_data was clamped
- done  out  1  one-cycle pulse after last coefficient of block consumed
- q_monitor  out  8  table value at current input index (combinational)

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, out_valid=0, out_data=0, out_index=0, sat_flag=0, done=0. Reset mid-block discards the block; next block starts at index 0.
- Table, row-major index 0..63:
  - 16 11 10 16 24 40 51 61
  - 12 12 14 19 26 58 60 55
  - 14 13 16 24 40 57 69 56
  - 14 17 22 29 51 87 80 62
  - 18 22 37 56 68 109 103 77
  - 24 35 55 64 81 104 113 92
  - 49 64 78 87 103 121 120 101
  - 72 92 95 98 112 100 103 99
- q_monitor = table[counter] at all times, including IDLE (=16 when counter=0).
- State IDLE:
  - in_ready=0; done deasserts after its 1-cycle pulse.
  - start=1 -> RUN with counter=0. start is ignored outside IDLE.
- State RUN:
  - in_ready = !out_valid | out_ready.
  - Accept when in_valid & in_ready:
    - product = in_data * {1'b0,table[counter]} as 25-bit signed.
    - out_data <= product clamped to [-32768, 32767]; sat_flag <= 1 if clamped.
    - out_index <= counter; out_valid <= 1; counter <= counter+1.
  - If counter==63 on accept: counter wraps to 0, state -> DRAIN.
  - No accept but out_valid & out_ready: out_valid <= 0.
  - Output register holds out_data, out_index and sat_flag stable while out_valid & !out_ready.
- State DRAIN:
  - in_ready=0.
  - When out_valid & out_ready (or out_valid=0): out_valid <= 0, done <= 1 for one cycle, state -> IDLE.
  - start in the done cycle is accepted (IDLE sees it).
- Latency: input accept at cycle N -> out_valid at N+1. Throughput is 64 cycles per block with out_ready held high, plus 2 cycles (DRAIN, done) before the next start.
- Simultaneous output handshake and new input accept in RUN: output register reloads with no bubble.
- in_valid is ignored in IDLE and DRAIN; in_ready=0 there.
- Zero input gives 0 output, sat_flag=0. Sign is preserved exactly: no rounding, since multiplication is exact.

Test Plan:
- Reset, start, 64 inputs of 1, out_ready=1 -> out_data sequence equals table (16,11,10,...,99); out_index 0..63; done pulses exactly one cycle after the 64th output handshake.
- Index 1 input -3; index 37 input 5 -> out_data -33 and 545; sat_flag=0.
- Index 0 input 32767 -> 32767 with sat_flag=1. Index 0 input -32768 -> -32768 with sat_flag=1. Index 0 input 2047 -> 32752 with sat_flag=0. With SAT_EN=0, 32767 at index 0 -> 16'hFFF0 (-16).
- Backpressure: out_ready=0 for 5 cycles at index 10 -> out_data, out_index=10 and sat_flag held stable; in_ready=0; no input lost. Release -> stream resumes at index 11.
- Assert rst at index 20 mid-block -> all outputs 0 immediately. Next start with inputs of 1 -> first out_data=16, out_index=0.
- start pulsed during RUN -> ignored, counter unaffected. start held high through done -> second block begins the cycle after done; q_monitor=16 at its first accept.
